fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-002 Parameter AW, default 8, PC width.
REQ-003 Parameter IW, default 32, instruction width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  pc_in/inst_in pair valid this cycle (combinational memory read).
REQ-007 pc_in  input  AW  PC of the offered instruction.
REQ-008 inst_in  input  IW  instruction word read at pc_in.
REQ-009 fetch_en  output  1  permits the upstream PC to advance this cycle.
REQ-010 flush  input  1  synchronous discard of all queued entries.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  decode consumes the head entry.
REQ-013 out_pc  output  AW  PC of the head entry.
REQ-014 out_inst  output  IW  instruction of the head entry.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries.
REQ-016 full  output  1  count == DEPTH.
REQ-017 empty  output  1  count == 0.

Function
REQ-018 Storage: circular buffer of DEPTH {pc, inst} entries; rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-019 pop = out_valid && out_ready.
REQ-020 push = in_valid && (!full || pop).
REQ-021 fetch_en = !full || out_ready, combinational; asserted only when a push would be accepted.
REQ-022 Push writes {pc_in, inst_in} at wr_ptr and increments wr_ptr on the same edge.
REQ-023 Pop increments rd_ptr on the edge.
REQ-024 count: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-025 Show-ahead: out_pc/out_inst are driven from entry rd_ptr with no added latency; out_valid = !empty.
REQ-026 Fill latency: an entry pushed at edge N is visible with out_valid=1 after edge N; no same-cycle bypass from input to output.
REQ-027 While out_valid=0, out_pc and out_inst hold their last values; decode ignores them.
REQ-028 Push while full and not popping is dropped: no pointer or count change, storage unchanged.
REQ-029 out_ready while empty is ignored: no pointer or count change.
REQ-030 Full with simultaneous pop and push: both occur, count stays DEPTH.
REQ-031 flush=1 at an edge: rd_ptr, wr_ptr and count all go to 0, and any push or pop in that cycle is discarded; flush takes priority over everything.
REQ-032 During flush, fetch_en follows REQ-021 unchanged; the PC redirect belongs to the upstream block.
REQ-033 count never exceeds DEPTH and never underflows.

Reset
REQ-034 rst low clears rd_ptr, wr_ptr and count to 0 immediately without waiting for clk: out_valid=0, empty=1, full=0, fetch_en=1.
REQ-035 Reset clears out_pc and out_inst to 0; entry storage needs no reset.
REQ-036 Reset asserted mid-operation drops all entries; the first push after rst rises lands at index 0.

Verification
REQ-037 Reset, then in_valid=1 with pc_in=0x00, inst_in=0xDEADBEEF, out_ready=0 -> after 1 edge out_valid=1, out_pc=0x00, out_inst=0xDEADBEEF, count=1.
REQ-038 DEPTH=4: push pc 0..5 back-to-back, out_ready=0 -> count=4, full=1, fetch_en=0; pc 4 and 5 are dropped; the head stays pc 0.
REQ-039 Full queue, out_ready=1 and in_valid=1 for 8 cycles with incrementing pc -> count stays 4 and out_pc steps 0,1,2,... in order with no gaps; this also exercises pointer wrap.
REQ-040 Queue holding 3 entries, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1, out_valid=0; the pushed entry is not stored.
REQ-041 Queue holding 2 entries, rst driven low between clock edges -> out_valid=0 and count=0 immediately; after release, a push of pc 0x10 appears as the head.
REQ-042 Empty queue, out_ready=1, in_valid=0 for 3 cycles -> count stays 0 and no pointer change.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module      : fetch_queue
//  Description : Show-ahead instruction fetch queue that sits between the PC
//                and instruction-memory stage and the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int IW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [AW-1:0]              pc_in,
   input  logic [IW-1:0]              inst_in,
   output logic                       fetch_en,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [AW-1:0]              out_pc,
   output logic [IW-1:0]              out_inst,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;

   localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
   localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

   logic [AW-1:0]   r_mem_pc   [DEPTH];
   logic [IW-1:0]   r_mem_inst [DEPTH];

   logic [c_PW-1:0] r_rd_ptr;
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_CW-1:0] r_count;
   logic [AW-1:0]   r_hold_pc;
   logic [IW-1:0]   r_hold_inst;

   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push;
   logic            w_wr_en;
   logic [AW-1:0]   w_head_pc;
   logic [IW-1:0]   w_head_inst;

   assign w_full      = (r_count == c_DEPTH_CNT);
   assign w_empty     = (r_count == '0);
   assign w_pop       = !w_empty && out_ready;
   assign w_push      = in_valid && (!w_full || w_pop);
   assign w_wr_en     = w_push && !flush;
   assign w_head_pc   = r_mem_pc[r_rd_ptr];
   assign w_head_inst = r_mem_inst[r_rd_ptr];

   // Entry storage carries no reset; only entries behind wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem_pc[r_wr_ptr]   <= pc_in;
         r_mem_inst[r_wr_ptr] <= inst_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Tracks the head shown while valid so the outputs hold once the queue drains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_pc   <= '0;
         r_hold_inst <= '0;
      end else if (!w_empty) begin
         r_hold_pc   <= w_head_pc;
         r_hold_inst <= w_head_inst;
      end
   end

   assign out_valid = !w_empty;
   assign out_pc    = w_empty ? r_hold_pc   : w_head_pc;
   assign out_inst  = w_empty ? r_hold_inst : w_head_inst;
   assign fetch_en  = !w_full || out_ready;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed, table-driven self-checking bench for fetch_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 8;
   localparam int IW    = 32;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [AW-1:0] pc_in;
   logic [IW-1:0] inst_in;
   logic          fetch_en;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_pc;
   logic [IW-1:0] out_inst;
   logic [2:0]    count;
   logic          full;
   logic          empty;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .pc_in     (pc_in),
      .inst_in   (inst_in),
      .fetch_en  (fetch_en),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [AW-1:0] pc;
      logic [IW-1:0] inst;
      logic          rdy;
      logic          fl;
      logic          fen;
      logic          ov;
      logic [AW-1:0] epc;
      logic [IW-1:0] einst;
      logic [2:0]    cnt;
      logic          efull;
      logic          eempty;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [IW-1:0] ins(input logic [AW-1:0] p);
      return 32'hC0DE_0000 | {24'h0, p};
   endfunction

   task automatic add(input logic iv, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                      input logic rdy, input logic fl, input logic fen, input logic ov,
                      input logic [AW-1:0] epc, input logic [IW-1:0] einst,
                      input logic [2:0] cnt, input logic efull, input logic eempty);
      vec_t v;
      v.iv = iv; v.pc = pc; v.inst = inst; v.rdy = rdy; v.fl = fl;
      v.fen = fen; v.ov = ov; v.epc = epc; v.einst = einst;
      v.cnt = cnt; v.efull = efull; v.eempty = eempty;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input logic ov, input logic [AW-1:0] epc,
                            input logic [IW-1:0] einst, input logic [2:0] cnt,
                            input logic efull, input logic eempty);
      chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, ov});
      chk({tag, ".out_pc"},    {24'h0, out_pc},    {24'h0, epc});
      chk({tag, ".out_inst"},  out_inst,           einst);
      chk({tag, ".count"},     {29'h0, count},     {29'h0, cnt});
      chk({tag, ".full"},      {31'h0, full},      {31'h0, efull});
      chk({tag, ".empty"},     {31'h0, empty},     {31'h0, eempty});
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; pc_in = '0; inst_in = '0;
      flush = 1'b0; out_ready = 1'b0;

      // Initial reset state, observed while reset is still asserted.
      #3;
      chk_state("reset", 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b1);
      chk("reset.fetch_en", {31'h0, fetch_en}, 32'h1);

      // Fill: first entry, then to full, then two dropped pushes.
      add(1, 8'h00, 32'hDEADBEEF, 0, 0,  1, 1, 8'h00, 32'hDEADBEEF, 3'd1, 0, 0);
      add(1, 8'h01, ins(8'h01),   0, 0,  1, 1, 8'h00, 32'hDEADBEEF, 3'd2, 0, 0);
      add(1, 8'h02, ins(8'h02),   0, 0,  1, 1, 8'h00, 32'hDEADBEEF, 3'd3, 0, 0);
      add(1, 8'h03, ins(8'h03),   0, 0,  1, 1, 8'h00, 32'hDEADBEEF, 3'd4, 1, 0);
      add(1, 8'h04, ins(8'h04),   0, 0,  0, 1, 8'h00, 32'hDEADBEEF, 3'd4, 1, 0);
      add(1, 8'h05, ins(8'h05),   0, 0,  0, 1, 8'h00, 32'hDEADBEEF, 3'd4, 1, 0);
      // Full streaming: pop and push together, pointers wrap.
      for (int k = 0; k < 8; k++) begin
         add(1, 8'(4 + k), ins(8'(4 + k)), 1, 0,  1, 1, 8'(1 + k), ins(8'(1 + k)), 3'd4, 1, 0);
      end
      // Drain; outputs hold the last head once empty.
      add(0, 8'hFF, 32'hFFFF_FFFF, 1, 0,  1, 1, 8'h09, ins(8'h09), 3'd3, 0, 0);
      add(0, 8'hFF, 32'hFFFF_FFFF, 1, 0,  1, 1, 8'h0A, ins(8'h0A), 3'd2, 0, 0);
      add(0, 8'hFF, 32'hFFFF_FFFF, 1, 0,  1, 1, 8'h0B, ins(8'h0B), 3'd1, 0, 0);
      add(0, 8'hFF, 32'hFFFF_FFFF, 1, 0,  1, 0, 8'h0B, ins(8'h0B), 3'd0, 0, 1);
      // out_ready while empty is ignored.
      for (int k = 0; k < 3; k++) begin
         add(0, 8'hEE, 32'hEEEE_EEEE, 1, 0,  1, 0, 8'h0B, ins(8'h0B), 3'd0, 0, 1);
      end
      // Three entries, then flush with simultaneous push and pop.
      add(1, 8'h20, ins(8'h20), 0, 0,  1, 1, 8'h20, ins(8'h20), 3'd1, 0, 0);
      add(1, 8'h21, ins(8'h21), 0, 0,  1, 1, 8'h20, ins(8'h20), 3'd2, 0, 0);
      add(1, 8'h22, ins(8'h22), 0, 0,  1, 1, 8'h20, ins(8'h20), 3'd3, 0, 0);
      add(1, 8'h23, ins(8'h23), 1, 1,  1, 0, 8'h20, ins(8'h20), 3'd0, 0, 1);
      add(1, 8'h30, ins(8'h30), 0, 0,  1, 1, 8'h30, ins(8'h30), 3'd1, 0, 0);
      add(1, 8'h31, ins(8'h31), 0, 0,  1, 1, 8'h30, ins(8'h30), 3'd2, 0, 0);

      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid  = vecs[i].iv;
         pc_in     = vecs[i].pc;
         inst_in   = vecs[i].inst;
         out_ready = vecs[i].rdy;
         flush     = vecs[i].fl;
         #1;
         chk($sformatf("v%0d.fetch_en", i), {31'h0, fetch_en}, {31'h0, vecs[i].fen});
         @(posedge clk);
         #1;
         chk_state($sformatf("v%0d", i), vecs[i].ov, vecs[i].epc, vecs[i].einst,
                   vecs[i].cnt, vecs[i].efull, vecs[i].eempty);
      end

      // Asynchronous reset between edges with two entries queued.
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk_state("async_rst", 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b1);
      chk("async_rst.fetch_en", {31'h0, fetch_en}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1; pc_in = 8'h10; inst_in = ins(8'h10);
      @(posedge clk);
      #1;
      chk_state("post_rst", 1'b1, 8'h10, ins(8'h10), 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
